conv_sched_ctrl: RTL and testbench
==================================

# conv_sched_ctrl

Sequencing controller for the 1-D convolution MAC datapath. It waits for the X buffer to report full. For each of the N−M+1 outputs, it then issues M paired X-memory/F-ROM read addresses and the matching delayed multiply-register and accumulate enables. It clears the accumulator between outputs, holds each result under a valid/ready output handshake, and pulses done so the X buffer can be released for the next vector.

## Interface
- N, 128, X vector length (X memory depth).
- M, 32, filter length (F ROM depth); 1 ≤ M ≤ N.
- RD_LAT, 1, read latency of X memory and F ROM in cycles (≥1).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- conv_start  in  1  X buffer full; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in any state.
- m_ready_y  in  1  downstream ready for output Y.
- xmem_addr  out  $clog2(N)  X memory read address.
- fmem_addr  out  $clog2(M)  F ROM read address.
- en_mult  out  1  load the multiply register (product valid this cycle).
- en_accum  out  1  accumulate the multiply register into the adder register.
- reset_accum  out  1  synchronous clear of the multiply, adder and output registers.
- m_valid_y  out  1  result in the accumulator is valid.
- conv_done  out  1  one-cycle pulse after the last output is accepted.
- busy  out  1  state ≠ IDLE.

## Operation
- All outputs are Moore outputs: they decode from state, counters and the delay pipe only. There is no input→output combinational path.
- Counters:
  - out_idx counts 0..N−M.
  - f_idx counts 0..M−1.
  - xmem_addr = out_idx + f_idx (max N−1, no wrap).
  - fmem_addr = f_idx.
  - Both addresses are 0 outside RUN.
- Delay pipe: an RD_LAT+1-bit shift register of issue = (state==RUN).
  - en_mult = issue delayed RD_LAT.
  - en_accum = issue delayed RD_LAT+1.
- States:
  - IDLE: reset_accum=1. If conv_start, go to RUN with out_idx=0 and f_idx=0.
  - RUN: issues one address pair per cycle and increments f_idx. When f_idx==M−1, go to DRAIN with f_idx=0.
  - DRAIN: waits until the pipe is empty (exactly RD_LAT+1 cycles), then goes to OUT.
  - OUT: m_valid_y=1; counters and addresses are frozen. On m_ready_y:
    - if out_idx==N−M, go to DONE;
    - otherwise increment out_idx and go to CLR.
  - CLR: reset_accum=1 for one cycle, then go to RUN.
  - DONE: conv_done=1 for one cycle, then go to IDLE.
- abort: in the next cycle the state is IDLE, counters are 0 and the pipe is cleared; conv_done is not asserted. abort takes priority over every other transition.
- conv_start high on the cycle after DONE is legal and starts a new convolution back-to-back.
- Reset values: state IDLE, counters 0, pipe 0. Resulting outputs: xmem_addr=0, fmem_addr=0, en_mult=0, en_accum=0, reset_accum=1, m_valid_y=0, conv_done=0, busy=0.

## Timing
- If conv_start is sampled high at edge k:
  - RUN spans cycles k+1..k+M.
  - en_accum is high for cycles k+RD_LAT+2..k+M+RD_LAT+1.
  - m_valid_y first rises in cycle k+M+RD_LAT+2. This is 35 cycles for the defaults.
- Per output: 1 (CLR/IDLE) + M + RD_LAT + 1 + handshake wait cycles.
- m_valid_y, once high, stays high until accepted; the handshake completes on the edge where m_valid_y & m_ready_y.
- conv_done is high in the cycle after the last handshake, and only that cycle.
- Asynchronous reset mid-operation: all outputs take their reset values immediately, without waiting for a clock edge; no partial result is preserved.

## Structure
- Package conv_ctrl_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN, OUT, CLR, DONE);
  - the address-width localparam functions.
- One sub-module, valid_delay: a parameterised-depth shift register with async active-low reset and a synchronous clear (driven by abort). It supplies en_mult and en_accum.
- Expected RTL size: about 200 lines total.

## Test plan
All scenarios use N=128, M=32, RD_LAT=1.
- Reset low mid-run → outputs at their reset values within the same cycle; busy=0, reset_accum=1.
- conv_start pulse at edge k, m_ready_y held 1 → first m_valid_y at k+35. Output 0 reads x 0..31 with f 0..31; output 96 reads x 96..127. Exactly 97 handshakes occur, then conv_done for one cycle.
- m_ready_y low for 5 cycles during OUT of output 3 → m_valid_y held 5 cycles; addresses, en_accum and out_idx unchanged; output 4 starts after the handshake plus one CLR cycle.
- abort at f_idx=10 of output 0 → next cycle IDLE; en_mult and en_accum are 0 thereafter; conv_done is never asserted.
- conv_start held high through DONE → a new RUN begins 2 cycles after the last handshake, with out_idx=0.
- Boundary N=M=32 → a single output with m_valid_y at k+35, then conv_done.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution sequencing controller.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_OUT,
    ST_CLR,
    ST_DONE
  } state_e;

  // Address width for a memory of the given depth; a depth-1 memory still gets one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int xaddr_w(input int n);
    return addr_w(n);
  endfunction

  function automatic int faddr_w(input int m);
    return addr_w(m);
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Shift register that delays the issue strobe to line up multiply and accumulate enables.
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  output logic [DEPTH-1:0] dout
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = DEPTH'({pipe_q, din});
    if (clr) pipe_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign dout = pipe_q;

endmodule

// File: rtl/conv_sched_ctrl.sv
// Sequencer for the 1-D convolution MAC: issues X/F read pairs per output, drains the
// pipe, and hands each accumulated result downstream under valid/ready.
//
// state | meaning
// IDLE  | waiting for conv_start; accumulator held in clear
// RUN   | one X/F address pair per cycle, f_idx 0..M-1
// DRAIN | let the last RD_LAT+1 pipe stages land in the accumulator
// OUT   | result valid, waiting for m_ready_y
// CLR   | one-cycle accumulator clear before the next output
// DONE  | one-cycle conv_done pulse
module conv_sched_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter  int N      = 128,
  parameter  int M      = 32,
  parameter  int RD_LAT = 1,
  localparam int XW     = xaddr_w(N),
  localparam int FW     = faddr_w(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          conv_start,
  input  logic          abort,
  input  logic          m_ready_y,
  output logic [XW-1:0] xmem_addr,
  output logic [FW-1:0] fmem_addr,
  output logic          en_mult,
  output logic          en_accum,
  output logic          reset_accum,
  output logic          m_valid_y,
  output logic          conv_done,
  output logic          busy
);

  localparam int            DW     = addr_w(RD_LAT + 1);
  localparam logic [FW-1:0] F_LAST = FW'(M - 1);
  localparam logic [XW-1:0] O_LAST = XW'(N - M);

  state_e          state_q, state_d;
  logic [XW-1:0]   out_idx_q, out_idx_d;
  logic [FW-1:0]   f_idx_q, f_idx_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [RD_LAT:0] pipe;
  logic            issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      out_idx_q <= '0;
      f_idx_q   <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
      f_idx_q   <= f_idx_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    f_idx_d   = f_idx_q;
    drain_d   = drain_q;
    if (abort) begin
      state_d   = ST_IDLE;
      out_idx_d = '0;
      f_idx_d   = '0;
      drain_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (conv_start) begin
            state_d   = ST_RUN;
            out_idx_d = '0;
            f_idx_d   = '0;
          end
        end
        ST_RUN: begin
          if (f_idx_q == F_LAST) begin
            state_d = ST_DRAIN;
            f_idx_d = '0;
            drain_d = DW'(RD_LAT);
          end else begin
            f_idx_d = f_idx_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Down-counter loaded with RD_LAT gives exactly RD_LAT+1 drain cycles.
          if (drain_q == '0) state_d = ST_OUT;
          else               drain_d = drain_q - 1'b1;
        end
        ST_OUT: begin
          if (m_ready_y) begin
            if (out_idx_q == O_LAST) begin
              state_d   = ST_DONE;
              out_idx_d = '0;
            end else begin
              state_d   = ST_CLR;
              out_idx_d = out_idx_q + 1'b1;
            end
          end
        end
        ST_CLR:  state_d = ST_RUN;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign issue = (state_q == ST_RUN);

  valid_delay #(
    .DEPTH (RD_LAT + 1)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (reset),
    .clr   (abort),
    .din   (issue),
    .dout  (pipe)
  );

  assign en_mult     = pipe[RD_LAT-1];
  assign en_accum    = pipe[RD_LAT];
  assign xmem_addr   = issue ? (out_idx_q + XW'(f_idx_q)) : '0;
  assign fmem_addr   = issue ? f_idx_q : '0;
  assign reset_accum = (state_q == ST_IDLE) || (state_q == ST_CLR);
  assign m_valid_y   = (state_q == ST_OUT);
  assign conv_done   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Directed bench for conv_sched_ctrl with a per-output scoreboard of expected read windows.
module tb_conv_sched_ctrl;

  localparam int N      = 128;
  localparam int M      = 32;
  localparam int RD_LAT = 1;
  localparam int NOUT   = N - M + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       a_conv_start = 1'b0, a_abort = 1'b0, a_m_ready_y = 1'b1;
  logic [6:0] a_xmem_addr;
  logic [4:0] a_fmem_addr;
  logic       a_en_mult, a_en_accum, a_reset_accum, a_m_valid_y, a_conv_done, a_busy;

  logic       b_conv_start = 1'b0, b_abort = 1'b0, b_m_ready_y = 1'b1;
  logic [4:0] b_xmem_addr;
  logic [4:0] b_fmem_addr;
  logic       b_en_mult, b_en_accum, b_reset_accum, b_m_valid_y, b_conv_done, b_busy;

  int errors = 0;
  int checks = 0;

  int sb_q[$];
  int hs_count = 0;
  int pair_cnt = 0, acc_cnt = 0, mon_base = 0;
  logic pairs_ok = 1'b1;
  int prev_x = 0, prev_f = 0;

  always #5 clk = ~clk;

  conv_sched_ctrl #(.N(N), .M(M), .RD_LAT(RD_LAT)) u_dut_a (
    .clk (clk), .reset (reset), .conv_start (a_conv_start), .abort (a_abort),
    .m_ready_y (a_m_ready_y), .xmem_addr (a_xmem_addr), .fmem_addr (a_fmem_addr),
    .en_mult (a_en_mult), .en_accum (a_en_accum), .reset_accum (a_reset_accum),
    .m_valid_y (a_m_valid_y), .conv_done (a_conv_done), .busy (a_busy)
  );

  conv_sched_ctrl #(.N(32), .M(32), .RD_LAT(1)) u_dut_b (
    .clk (clk), .reset (reset), .conv_start (b_conv_start), .abort (b_abort),
    .m_ready_y (b_m_ready_y), .xmem_addr (b_xmem_addr), .fmem_addr (b_fmem_addr),
    .en_mult (b_en_mult), .en_accum (b_en_accum), .reset_accum (b_reset_accum),
    .m_valid_y (b_m_valid_y), .conv_done (b_conv_done), .busy (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_xmem"},   32'(a_xmem_addr), 0);
    chk({tag, "_fmem"},   32'(a_fmem_addr), 0);
    chk({tag, "_mult"},   32'(a_en_mult), 0);
    chk({tag, "_accum"},  32'(a_en_accum), 0);
    chk({tag, "_rstacc"}, 32'(a_reset_accum), 1);
    chk({tag, "_valid"},  32'(a_m_valid_y), 0);
    chk({tag, "_done"},   32'(a_conv_done), 0);
    chk({tag, "_busy"},   32'(a_busy), 0);
  endtask

  // Reconstructs each output's read window from en_mult (RD_LAT=1: pair issued last cycle).
  always @(negedge clk) begin
    if (!reset) begin
      pair_cnt = 0; acc_cnt = 0; pairs_ok = 1'b1; prev_x = 0; prev_f = 0;
    end else begin
      if (a_reset_accum) begin
        pair_cnt = 0; acc_cnt = 0; pairs_ok = 1'b1;
      end
      if (a_en_mult) begin
        if (pair_cnt == 0) mon_base = prev_x;
        if (prev_f != pair_cnt || prev_x != mon_base + pair_cnt) pairs_ok = 1'b0;
        pair_cnt++;
      end
      if (a_en_accum) acc_cnt++;
      if (a_m_valid_y && a_m_ready_y) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          int eb;
          eb = sb_q.pop_front();
          chk("out_base", 32'(mon_base), 32'(eb));
          chk("out_pairs", 32'(pair_cnt), M);
          chk("out_accums", 32'(acc_cnt), M);
          chk("out_pair_order", 32'(pairs_ok), 1);
        end
      end
      prev_x = int'(a_xmem_addr);
      prev_f = int'(a_fmem_addr);
    end
  end

  initial begin
    int j, first_acc, t, stray, xmax;

    tick();
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // Run 1: ready held high throughout.
    a_conv_start = 1'b1;
    for (int o = 0; o < NOUT; o++) sb_q.push_back(o);
    tick();
    a_conv_start = 1'b0;
    j = 1; first_acc = 0;
    if (a_busy !== 1'b1 || a_reset_accum !== 1'b0) chk("run_entry", {a_busy, a_reset_accum}, 2);
    while (!a_m_valid_y && j < 200) begin
      if (a_en_accum && first_acc == 0) first_acc = j;
      tick();
      j++;
    end
    chk("first_valid_latency", j, M + RD_LAT + 2);
    chk("first_accum_latency", first_acc, RD_LAT + 2);
    t = 0;
    while (!a_conv_done && t < 20000) begin tick(); t++; end
    chk("run1_done_seen", 32'(a_conv_done), 1);
    chk("run1_handshakes", hs_count, NOUT);
    chk("run1_sb_drained", sb_q.size(), 0);
    tick();
    chk("run1_done_pulse", 32'(a_conv_done), 0);
    chk("run1_idle", 32'(a_busy), 0);

    // Run 2: stall on output 3, conv_start held high through DONE.
    a_conv_start = 1'b1;
    for (int o = 0; o < NOUT; o++) sb_q.push_back(o);
    t = 0;
    while (hs_count < NOUT + 3 && t < 1000) begin tick(); t++; end
    a_m_ready_y = 1'b0;
    t = 0;
    while (!a_m_valid_y && t < 200) begin tick(); t++; end
    chk("stall_valid_seen", 32'(a_m_valid_y), 1);
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid_held", 32'(a_m_valid_y), 1);
      chk("stall_xmem_frozen", 32'(a_xmem_addr), 0);
      chk("stall_accum_off", 32'(a_en_accum), 0);
      if (s == 4) a_m_ready_y = 1'b1;
      tick();
    end
    chk("clr_valid_drop", 32'(a_m_valid_y), 0);
    chk("clr_reset_accum", 32'(a_reset_accum), 1);
    chk("clr_busy", 32'(a_busy), 1);
    tick();
    chk("out4_xmem_f0", 32'(a_xmem_addr), 4);
    chk("out4_fmem_f0", 32'(a_fmem_addr), 0);
    tick();
    chk("out4_xmem_f1", 32'(a_xmem_addr), 5);
    t = 0;
    while (!a_conv_done && t < 20000) begin tick(); t++; end
    chk("run2_done_seen", 32'(a_conv_done), 1);
    chk("run2_handshakes", hs_count, 2 * NOUT);
    chk("run2_sb_drained", sb_q.size(), 0);
    tick();
    chk("b2b_idle_busy", 32'(a_busy), 0);
    chk("b2b_idle_rstacc", 32'(a_reset_accum), 1);
    tick();
    chk("b2b_run_busy", 32'(a_busy), 1);
    chk("b2b_run_rstacc", 32'(a_reset_accum), 0);
    chk("b2b_run_fmem", 32'(a_fmem_addr), 0);
    a_conv_start = 1'b0;

    // Abort at f_idx=10 of output 0 of the back-to-back run.
    t = 0;
    while (a_fmem_addr != 5'd10 && t < 50) begin tick(); t++; end
    chk("abort_point_xmem", 32'(a_xmem_addr), 10);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_idle", 32'(a_busy), 0);
    chk("abort_mult", 32'(a_en_mult), 0);
    stray = 0;
    for (int s = 0; s < 40; s++) begin
      if (a_en_mult || a_en_accum || a_conv_done || a_busy) stray++;
      tick();
    end
    chk("abort_quiet", stray, 0);
    chk("abort_no_output", hs_count, 2 * NOUT);

    // Asynchronous reset in the middle of RUN.
    a_conv_start = 1'b1;
    tick();
    a_conv_start = 1'b0;
    for (int s = 0; s < 4; s++) tick();
    chk("prereset_xmem", 32'(a_xmem_addr), 4);
    chk("prereset_mult", 32'(a_en_mult), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick();
    reset = 1'b1;
    tick();

    // Boundary instance: N = M = 32, a single output.
    b_conv_start = 1'b1;
    tick();
    b_conv_start = 1'b0;
    j = 1; t = 0; xmax = 0;
    while (!b_m_valid_y && j < 200) begin
      if (b_en_accum) t++;
      if (int'(b_xmem_addr) > xmax) xmax = int'(b_xmem_addr);
      tick();
      j++;
    end
    chk("nm_valid_latency", j, 35);
    chk("nm_accum_count", t, 32);
    chk("nm_xmem_max", xmax, 31);
    tick();
    chk("nm_done_pulse", 32'(b_conv_done), 1);
    tick();
    chk("nm_done_clear", 32'(b_conv_done), 0);
    chk("nm_idle", 32'(b_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
